traffic_lights: RTL and testbench

Single-intersection traffic light controller: one vehicle signal head (red/yellow/green) and one pedestrian head (ped_red/ped_green). It is a free-running, timer-driven state machine with no external requests. It cycles vehicle green, yellow and all-red clearance, then pedestrian walk and pedestrian clearance, and repeats. It sits at the top of the intersection logic and drives the lamp drivers directly.

---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/phase_timer.sv | 38 +++
 rtl/traffic_lights.sv | 132 +++++++++++++
 tb/tb_traffic_lights.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp patterns for the single-intersection traffic light.
// Lamp vectors are packed as {red, yellow, green, ped_red, ped_green}.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_GREEN  = 3'd0,
        S_YELLOW = 3'd1,
        S_ALLRED = 3'd2,
        S_WALK   = 3'd3,
        S_PEDCLR = 3'd4
    } state_e;

    typedef logic [4:0] lamps_t;

    localparam lamps_t LAMPS_GREEN  = 5'b00110;
    localparam lamps_t LAMPS_YELLOW = 5'b01010;
    localparam lamps_t LAMPS_ALLRED = 5'b10010;
    localparam lamps_t LAMPS_WALK   = 5'b10001;
    localparam lamps_t LAMPS_PEDCLR = 5'b10010;

    // A zero duration would skip a state; clamp it to one clock.
    function automatic int unsigned eff_cycles(input int unsigned c);
        return (c == 0) ? 1 : c;
    endfunction

    function automatic int unsigned max2(input int unsigned a,
                                         input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Unknown encodings show the safe all-red pattern.
    function automatic lamps_t lamps_of(input state_e s);
        lamps_t l;
        case (s)
            S_GREEN:  l = LAMPS_GREEN;
            S_YELLOW: l = LAMPS_YELLOW;
            S_ALLRED: l = LAMPS_ALLRED;
            S_WALK:   l = LAMPS_WALK;
            S_PEDCLR: l = LAMPS_PEDCLR;
            default:  l = LAMPS_ALLRED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one light phase.
// Holds at zero until reloaded, so it can never wrap.
module phase_timer #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register; reset preloads the first phase duration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_lights.sv
// Free-running vehicle/pedestrian signal controller for one intersection.
// Sequence: green, yellow, all-red, walk, pedestrian clearance, repeat.
module traffic_lights
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES  = 40,
    parameter int unsigned YELLOW_CYCLES = 10,
    parameter int unsigned ALLRED_CYCLES = 5,
    parameter int unsigned WALK_CYCLES   = 30,
    parameter int unsigned PEDCLR_CYCLES = 5
) (
    input  logic clk,
    input  logic reset,
    output logic red,
    output logic yellow,
    output logic green,
    output logic ped_red,
    output logic ped_green
);

    localparam int unsigned G_EFF  = eff_cycles(GREEN_CYCLES);
    localparam int unsigned Y_EFF  = eff_cycles(YELLOW_CYCLES);
    localparam int unsigned AR_EFF = eff_cycles(ALLRED_CYCLES);
    localparam int unsigned W_EFF  = eff_cycles(WALK_CYCLES);
    localparam int unsigned PC_EFF = eff_cycles(PEDCLR_CYCLES);

    localparam int unsigned MAX_D =
        max2(max2(max2(G_EFF, Y_EFF), max2(AR_EFF, W_EFF)), PC_EFF);
    localparam int unsigned CW = $clog2(MAX_D + 1);

    localparam logic [CW-1:0] G_LD  = CW'(G_EFF - 1);
    localparam logic [CW-1:0] Y_LD  = CW'(Y_EFF - 1);
    localparam logic [CW-1:0] AR_LD = CW'(AR_EFF - 1);
    localparam logic [CW-1:0] W_LD  = CW'(W_EFF - 1);
    localparam logic [CW-1:0] PC_LD = CW'(PC_EFF - 1);

    function automatic logic [CW-1:0] load_of(input state_e s);
        logic [CW-1:0] v;
        case (s)
            S_GREEN:  v = G_LD;
            S_YELLOW: v = Y_LD;
            S_ALLRED: v = AR_LD;
            S_WALK:   v = W_LD;
            S_PEDCLR: v = PC_LD;
            default:  v = AR_LD;
        endcase
        return v;
    endfunction

    state_e        state_q;
    state_e        state_d;
    logic          boot_q;
    logic          boot_d;
    lamps_t        lamps_q;
    logic          done;
    logic          load;
    logic [CW-1:0] load_val;

    phase_timer #(
        .W       (CW),
        .RST_VAL (AR_LD)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .done_o     (done)
    );

    // Next state and timer reload. The all-red phase entered from reset
    // (boot_q set) exits straight to green instead of to walk.
    always_comb begin
        state_d = state_q;
        boot_d  = boot_q;
        load    = 1'b0;
        case (state_q)
            S_GREEN: begin
                if (done) begin
                    state_d = S_YELLOW;
                    load    = 1'b1;
                end
            end
            S_YELLOW: begin
                if (done) begin
                    state_d = S_ALLRED;
                    load    = 1'b1;
                end
            end
            S_ALLRED: begin
                if (done) begin
                    state_d = boot_q ? S_GREEN : S_WALK;
                    boot_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            S_WALK: begin
                if (done) begin
                    state_d = S_PEDCLR;
                    load    = 1'b1;
                end
            end
            S_PEDCLR: begin
                if (done) begin
                    state_d = S_GREEN;
                    load    = 1'b1;
                end
            end
            default: begin
                state_d = S_ALLRED;
                boot_d  = 1'b1;
                load    = 1'b1;
            end
        endcase
        load_val = load_of(state_d);
    end

    // State, boot flag and registered lamp decode share one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ALLRED;
            boot_q  <= 1'b1;
            lamps_q <= LAMPS_ALLRED;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            lamps_q <= lamps_of(state_d);
        end
    end

    assign {red, yellow, green, ped_red, ped_green} = lamps_q;

endmodule

// File: tb/tb_traffic_lights.sv
// Self-checking bench for traffic_lights: three parameter sets,
// a boundary-vector table, a timeline model and random reset pulses.
module tb_traffic_lights;

    localparam logic [4:0] LG = 5'b00110;
    localparam logic [4:0] LY = 5'b01010;
    localparam logic [4:0] LR = 5'b10010;
    localparam logic [4:0] LW = 5'b10001;

    typedef struct {
        int         dut;
        int         k;
        logic [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    logic r_a, y_a, g_a, pr_a, pg_a;
    logic r_b, y_b, g_b, pr_b, pg_b;
    logic r_c, y_c, g_c, pr_c, pg_c;
    logic [4:0] lamps_a, lamps_b, lamps_c;

    int checks = 0;
    int errors = 0;
    int k_a = 0;
    int k_b = 0;
    bit use_tbl = 1'b0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    traffic_lights u_a (
        .clk(clk), .reset(rst_a),
        .red(r_a), .yellow(y_a), .green(g_a),
        .ped_red(pr_a), .ped_green(pg_a)
    );

    traffic_lights #(
        .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1),
        .WALK_CYCLES(1), .PEDCLR_CYCLES(1)
    ) u_b (
        .clk(clk), .reset(rst_b),
        .red(r_b), .yellow(y_b), .green(g_b),
        .ped_red(pr_b), .ped_green(pg_b)
    );

    traffic_lights #(
        .GREEN_CYCLES(3), .YELLOW_CYCLES(0), .ALLRED_CYCLES(2),
        .WALK_CYCLES(4), .PEDCLR_CYCLES(2)
    ) u_c (
        .clk(clk), .reset(rst_b),
        .red(r_c), .yellow(y_c), .green(g_c),
        .ped_red(pr_c), .ped_green(pg_c)
    );

    assign lamps_a = {r_a, y_a, g_a, pr_a, pg_a};
    assign lamps_b = {r_b, y_b, g_b, pr_b, pg_b};
    assign lamps_c = {r_c, y_c, g_c, pr_c, pg_c};

    // Expected lamps k clocks after reset release: an all-red boot
    // phase, then the five-phase period starting from green.
    function automatic logic [4:0] model(int g, int y, int ar,
                                         int w, int pc, int k);
        int m;
        int p;
        if (g < 1) g = 1;
        if (y < 1) y = 1;
        if (ar < 1) ar = 1;
        if (w < 1) w = 1;
        if (pc < 1) pc = 1;
        if (k < ar) return LR;
        p = g + y + ar + w + pc;
        m = (k - ar) % p;
        if (m < g) return LG;
        m -= g;
        if (m < y) return LY;
        m -= y;
        if (m < ar) return LR;
        m -= ar;
        if (m < w) return LW;
        return LR;
    endfunction

    function automatic logic [4:0] pick(int d);
        if (d == 0) return lamps_a;
        if (d == 1) return lamps_b;
        return lamps_c;
    endfunction

    task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic safe(string name, logic [4:0] l);
        bit ok;
        checks++;
        ok = $onehot(l[4:2]) && $onehot(l[1:0])
             && !(l[2] && l[0]) && (!l[0] || l[4]);
        if (!ok) begin
            errors++;
            $display("FAIL %s: unsafe lamps %b (t=%0t)", name, l, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k_a++;
        k_b++;
        chk("model_a", lamps_a, model(40, 10, 5, 30, 5, k_a));
        chk("model_b", lamps_b, model(1, 1, 1, 1, 1, k_b));
        chk("model_c", lamps_c, model(3, 0, 2, 4, 2, k_b));
        safe("safe_a", lamps_a);
        safe("safe_b", lamps_b);
        safe("safe_c", lamps_c);
        if (use_tbl) begin
            foreach (tbl[i]) begin
                if (tbl[i].k == ((tbl[i].dut == 0) ? k_a : k_b))
                    chk($sformatf("tbl%0d_k%0d", tbl[i].dut, tbl[i].k),
                        pick(tbl[i].dut), tbl[i].exp);
            end
        end
    endtask

    initial begin
        int n;
        int sel;
        int off;

        tbl.push_back('{0, 1, LR});
        tbl.push_back('{0, 4, LR});
        tbl.push_back('{0, 5, LG});
        tbl.push_back('{0, 44, LG});
        tbl.push_back('{0, 45, LY});
        tbl.push_back('{0, 54, LY});
        tbl.push_back('{0, 55, LR});
        tbl.push_back('{0, 59, LR});
        tbl.push_back('{0, 60, LW});
        tbl.push_back('{0, 89, LW});
        tbl.push_back('{0, 90, LR});
        tbl.push_back('{0, 94, LR});
        tbl.push_back('{0, 95, LG});
        tbl.push_back('{0, 134, LG});
        tbl.push_back('{0, 135, LY});
        tbl.push_back('{0, 184, LR});
        tbl.push_back('{0, 185, LG});
        tbl.push_back('{1, 1, LG});
        tbl.push_back('{1, 2, LY});
        tbl.push_back('{1, 3, LR});
        tbl.push_back('{1, 4, LW});
        tbl.push_back('{1, 5, LR});
        tbl.push_back('{1, 6, LG});
        tbl.push_back('{2, 4, LG});
        tbl.push_back('{2, 5, LY});
        tbl.push_back('{2, 6, LR});
        tbl.push_back('{2, 9, LW});

        @(negedge clk);
        chk("rst_a", lamps_a, LR);
        chk("rst_b", lamps_b, LR);
        chk("rst_c", lamps_c, LR);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        k_a = 0;
        k_b = 0;

        use_tbl = 1'b1;
        for (int i = 0; i < 200; i++) step();
        use_tbl = 1'b0;

        for (int i = 0; i < 100 && model(40, 10, 5, 30, 5, k_a) != LW; i++)
            step();
        repeat (3) step();
        chk("in_walk", lamps_a, LW);
        #2 rst_a = 1'b0;
        #1 chk("async_rst_walk", lamps_a, LR);
        #2 rst_a = 1'b1;
        k_a = 0;
        repeat (4) step();
        chk("boot_allred", lamps_a, LR);
        step();
        chk("boot_green", lamps_a, LG);

        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 120);
            repeat (n) step();
            sel = $urandom_range(0, 2);
            off = $urandom_range(1, 3);
            #off;
            if (sel != 1) rst_a = 1'b0;
            if (sel != 0) rst_b = 1'b0;
            #1;
            if (sel != 1) chk("rnd_rst_a", lamps_a, LR);
            if (sel != 0) begin
                chk("rnd_rst_b", lamps_b, LR);
                chk("rnd_rst_c", lamps_c, LR);
            end
            #1;
            if (sel != 1) begin
                rst_a = 1'b1;
                k_a = 0;
            end
            if (sel != 0) begin
                rst_b = 1'b1;
                k_b = 0;
            end
        end
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
